// File: rtl/als_sample_sched.sv
// Ambient-light sample scheduler. It requests a conversion every PERIOD_CYCLES, supervises
// each reply with a timeout, and publishes the truncated mean of 2**AVG_LOG2 good samples.
module als_sample_sched #(
  parameter int PERIOD_CYCLES  = 100000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AVG_LOG2       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       conv_start,
  input  logic       conv_done,
  input  logic [7:0] conv_data,
  output logic [7:0] avg_data,
  output logic       avg_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = AVG_LOG2 + 1;
  localparam int AW = 8 + AVG_LOG2;

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLES_FULL = SW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    CONVERT,
    PUBLISH
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] samples_q, samples_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    avg_data_q, avg_data_d;
  logic          avg_valid_q, avg_valid_d;
  logic          conv_start_q, conv_start_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          tick;

  assign tick = (period_q == PERIOD_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d       = state_q;
    tmo_d         = tmo_q;
    samples_d     = samples_q;
    acc_d         = acc_q;
    avg_data_d    = avg_data_q;
    avg_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    conv_start_d  = (state_q == START);
    period_d      = (state_q == IDLE || tick) ? '0 : period_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) state_d = START;
      end
      START: begin
        tmo_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        // A reply in the final timeout cycle still counts as a good sample.
        if (conv_done) begin
          acc_d     = acc_q + AW'(conv_data);
          samples_d = samples_q + SW'(1);
          state_d   = (samples_d == SAMPLES_FULL) ? PUBLISH : WAIT_TICK;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = WAIT_TICK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PUBLISH: begin
        avg_data_d  = acc_q[AVG_LOG2 +: 8];
        avg_valid_d = 1'b1;
        acc_d       = '0;
        samples_d   = '0;
        state_d     = WAIT_TICK;
      end
      default: state_d = IDLE;
    endcase

    // Disabling aborts everything except the last published value; a request pulse
    // already in flight from START still completes through conv_start_d.
    if (!enable) begin
      state_d       = IDLE;
      period_d      = '0;
      acc_d         = '0;
      samples_d     = '0;
      timeout_err_d = 1'b0;
      avg_valid_d   = 1'b0;
      avg_data_d    = avg_data_q;
    end

    busy_d = (state_d == START) || (state_d == CONVERT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      period_q      <= '0;
      tmo_q         <= '0;
      samples_q     <= '0;
      acc_q         <= '0;
      avg_data_q    <= '0;
      avg_valid_q   <= 1'b0;
      conv_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values,
      // independent of statement order.
      state_q       <= state_d;
      period_q      <= period_d;
      tmo_q         <= tmo_d;
      samples_q     <= samples_d;
      acc_q         <= acc_d;
      avg_data_q    <= avg_data_d;
      avg_valid_q   <= avg_valid_d;
      conv_start_q  <= conv_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign conv_start  = conv_start_q;
  assign avg_data    = avg_data_q;
  assign avg_valid   = avg_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_als_sample_sched.sv
// Bench for als_sample_sched: a transaction-level model (running sum of accepted samples,
// a fixed 20-cycle request schedule, a sticky error flag) predicts every observed output.
module tb_als_sample_sched;

  localparam int PERIOD  = 20;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, conv_done;
  logic [7:0] conv_data;
  logic       conv_start, avg_valid, busy, timeout_err;
  logic [7:0] avg_data;

  logic       en0, done0;
  logic [7:0] data0;
  logic       start0, valid0, busy0, terr0;
  logic [7:0] avg0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int next_start;
  int m_sum, m_cnt;
  bit exp_terr;

  always #5 clk = ~clk;

  als_sample_sched #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TIMEOUT), .AVG_LOG2(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .conv_start(conv_start),
    .conv_done(conv_done), .conv_data(conv_data), .avg_data(avg_data),
    .avg_valid(avg_valid), .busy(busy), .timeout_err(timeout_err)
  );

  als_sample_sched #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TIMEOUT), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .conv_start(start0),
    .conv_done(done0), .conv_data(data0), .avg_data(avg0),
    .avg_valid(valid0), .busy(busy0), .timeout_err(terr0)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for the next request pulse and checks it lands on the predicted cycle.
  task automatic wait_start(output int p);
    while (conv_start !== 1'b1 && cyc < next_start + 3) step();
    vectors++;
    if (conv_start !== 1'b1 || cyc != next_start) begin
      miscompares++;
      $display("FAIL start_time: got cycle %0d (conv_start=%b) expected cycle %0d",
               cyc, conv_start, next_start);
    end
    p = cyc;
    next_start += PERIOD;
  endtask

  // One scheduled conversion. reply=0 lets it time out; k is the reply delay after the
  // request pulse; stray adds an extra conv_done once the FSM is back to waiting.
  task automatic do_conv(input bit reply, input int k, input logic [7:0] d, input bit stray);
    int p;
    bit complete;
    logic [7:0] exp_avg;
    complete = 1'b0;
    exp_avg  = '0;
    if (reply) begin
      m_sum += int'(d);
      m_cnt++;
      if (m_cnt == 4) begin
        complete = 1'b1;
        exp_avg  = 8'(m_sum / 4);
        m_sum    = 0;
        m_cnt    = 0;
      end
    end else begin
      exp_terr = 1'b1;
    end

    wait_start(p);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_convert: got %b expected 1", busy);
    end

    for (int i = 0; i < 10; i++) begin
      if (reply && i == k) begin
        conv_done = 1'b1;
        conv_data = d;
      end
      if (stray && i == 9) begin
        conv_done = 1'b1;
        conv_data = 8'($urandom);
      end
      step();
      conv_done = 1'b0;
      conv_data = 8'($urandom);
      if (i == 0) begin
        vectors++;
        if (conv_start !== 1'b0) begin
          miscompares++;
          $display("FAIL start_pulse_width: got %b expected 0", conv_start);
        end
      end
      vectors++;
      if (avg_valid !== (complete && i + 1 == k + 2)) begin
        miscompares++;
        $display("FAIL avg_valid_timing: offset %0d got %b expected %b",
                 i + 1, avg_valid, (complete && i + 1 == k + 2));
      end
      if (complete && i + 1 == k + 2) begin
        vectors++;
        if (avg_data !== exp_avg) begin
          miscompares++;
          $display("FAIL avg_data: got %0d expected %0d", avg_data, exp_avg);
        end
      end
      if (!reply && i + 1 == TIMEOUT) begin
        vectors++;
        if (timeout_err !== 1'b1) begin
          miscompares++;
          $display("FAIL timeout_set: got %b expected 1", timeout_err);
        end
      end
    end

    vectors++;
    if (timeout_err !== exp_terr || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_conv_flags: got terr=%b busy=%b expected terr=%b busy=0",
               timeout_err, busy, exp_terr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; conv_done = 1'b0; conv_data = '0;
    en0 = 1'b0; done0 = 1'b0; data0 = '0;
    m_sum = 0; m_cnt = 0; exp_terr = 1'b0;
    repeat (3) step();
    vectors++;
    if ({conv_start, avg_valid, busy, timeout_err, avg_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b_%b_%b_%b_%h expected all 0",
               conv_start, avg_valid, busy, timeout_err, avg_data);
    end
    vectors++;
    if ({start0, valid0, busy0, terr0, avg0} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs_log2zero: got %b_%b_%b_%b_%h expected all 0",
               start0, valid0, busy0, terr0, avg0);
    end
    rst_n = 1'b1;
    next_start = cyc + PERIOD + 2;
    step();
    vectors++;
    if (busy !== 1'b0 || conv_start !== 1'b0) begin
      miscompares++;
      $display("FAIL after_release: got busy=%b start=%b expected 0 0", busy, conv_start);
    end
  endtask

  task automatic test_average();
    do_conv(1'b1, 3, 8'd10, 1'b0);
    do_conv(1'b1, 3, 8'd20, 1'b0);
    do_conv(1'b1, 3, 8'd30, 1'b0);
    do_conv(1'b1, 3, 8'd41, 1'b0);
    vectors++;
    if (avg_data !== 8'd25) begin
      miscompares++;
      $display("FAIL average_hold: got %0d expected 25", avg_data);
    end
  endtask

  task automatic test_race();
    for (int j = 0; j < 3; j++) do_conv(1'b1, $urandom_range(0, 6), 8'($urandom), 1'b0);
    do_conv(1'b1, TIMEOUT - 1, 8'($urandom), 1'b0);
  endtask

  task automatic test_timeout();
    do_conv(1'b1, 2, 8'd100, 1'b0);
    do_conv(1'b0, 0, 8'd0, 1'b0);
    for (int j = 0; j < 3; j++) do_conv(1'b1, 4, 8'd100, 1'b0);
    vectors++;
    if (avg_data !== 8'd100 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recovery: got avg=%0d terr=%b expected 100 1", avg_data, timeout_err);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 14; j++)
      do_conv($urandom_range(0, 4) != 0, $urandom_range(0, TIMEOUT - 1), 8'($urandom), 1'b0);
  endtask

  task automatic test_abort();
    int starts_seen;
    do_conv(1'b1, 2, 8'd200, 1'b0);
    do_conv(1'b1, 2, 8'd200, 1'b0);
    while (cyc < next_start - 1) step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_start: got %b expected 1", busy);
    end
    enable = 1'b0;
    step();
    vectors++;
    if (conv_start !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pulse_completes: got %b expected 1", conv_start);
    end
    conv_done = 1'b1;
    conv_data = 8'd255;
    step();
    conv_done = 1'b0;
    vectors++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || conv_start !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b terr=%b start=%b expected 0 0 0",
               busy, timeout_err, conv_start);
    end
    m_sum = 0; m_cnt = 0; exp_terr = 1'b0;
    starts_seen = 0;
    repeat (30) begin
      step();
      if (conv_start === 1'b1 || avg_valid === 1'b1) starts_seen++;
    end
    vectors++;
    if (starts_seen != 0) begin
      miscompares++;
      $display("FAIL idle_quiet: got %0d pulses expected 0", starts_seen);
    end
    enable = 1'b1;
    next_start = cyc + PERIOD + 2;
    for (int j = 0; j < 4; j++) do_conv(1'b1, 3, 8'd8, 1'b0);
    vectors++;
    if (avg_data !== 8'd8) begin
      miscompares++;
      $display("FAIL abort_fresh_average: got %0d expected 8", avg_data);
    end
  endtask

  task automatic test_stray();
    for (int j = 0; j < 8; j++)
      do_conv(1'b1, $urandom_range(0, TIMEOUT - 1), 8'($urandom), 1'b1);
  endtask

  task automatic test_avg_log2_zero();
    int ns0;
    logic [7:0] d;
    enable = 1'b0;
    en0 = 1'b1;
    ns0 = cyc + PERIOD + 2;
    for (int j = 0; j < 4; j++) begin
      while (start0 !== 1'b1 && cyc < ns0 + 3) step();
      vectors++;
      if (start0 !== 1'b1 || cyc != ns0) begin
        miscompares++;
        $display("FAIL log2zero_start: got cycle %0d expected %0d", cyc, ns0);
      end
      ns0 += PERIOD;
      d = (j == 2) ? 8'($urandom) : 8'd255;
      done0 = 1'b1;
      data0 = d;
      step();
      done0 = 1'b0;
      vectors++;
      if (valid0 !== 1'b0) begin
        miscompares++;
        $display("FAIL log2zero_early_valid: got %b expected 0", valid0);
      end
      step();
      vectors++;
      if (valid0 !== 1'b1 || avg0 !== d) begin
        miscompares++;
        $display("FAIL log2zero_publish: got valid=%b avg=%0d expected 1 %0d", valid0, avg0, d);
      end
      step();
      vectors++;
      if (valid0 !== 1'b0) begin
        miscompares++;
        $display("FAIL log2zero_single_pulse: got %b expected 0", valid0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_race();
    test_timeout();
    test_random();
    test_abort();
    test_stray();
    test_avg_log2_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
